// File: rtl/alu_decode_stage.sv
// MIPS decode stage: one registered decoded instruction with valid/ready handshake, stall and flush.
// Optional trap on illegal encodings is enabled by defining DECODE_ILLEGAL_TRAP_EN.
module alu_decode_stage #(
  parameter int DWIDTH    = 32,
  parameter int PC_WIDTH  = 32,
  parameter int IMM_WIDTH = 16
) (
  input  logic                 d_clk,
  input  logic                 d_rst,
  input  logic [31:0]          d_i_instr,
  input  logic [PC_WIDTH-1:0]  d_i_pc,
  input  logic                 d_i_valid,
  output logic                 d_o_ready,
  input  logic                 d_i_ready,
  input  logic                 d_i_flush,
  output logic                 d_o_valid,
  output logic [4:0]           d_o_funct,
  output logic                 d_o_alu_src,
  output logic [IMM_WIDTH-1:0] d_o_imm,
  output logic [PC_WIDTH-1:0]  d_o_pc,
  output logic [4:0]           d_o_rs_addr,
  output logic [4:0]           d_o_rt_addr,
  output logic [4:0]           d_o_rd_addr,
  output logic                 d_o_reg_we,
  output logic                 d_o_mem_rd,
  output logic                 d_o_mem_wr,
  output logic                 d_o_branch,
  output logic                 d_o_illegal
);

  if (DWIDTH < 1 || IMM_WIDTH < 16 || PC_WIDTH < 1) begin : g_bad_param
    $error("alu_decode_stage: unsupported parameter combination");
  end

  localparam logic [4:0] FN_ADD  = 5'd0;
  localparam logic [4:0] FN_SUB  = 5'd1;
  localparam logic [4:0] FN_AND  = 5'd2;
  localparam logic [4:0] FN_OR   = 5'd3;
  localparam logic [4:0] FN_XOR  = 5'd4;
  localparam logic [4:0] FN_SLT  = 5'd5;
  localparam logic [4:0] FN_SLTU = 5'd6;
  localparam logic [4:0] FN_SLL  = 5'd7;
  localparam logic [4:0] FN_SRL  = 5'd8;
  localparam logic [4:0] FN_SRA  = 5'd9;
  localparam logic [4:0] FN_ADDU = 5'd14;
  localparam logic [4:0] FN_BEQ  = 5'd15;
  localparam logic [4:0] FN_BNE  = 5'd16;
  localparam logic [4:0] FN_NONE = 5'd31;

`ifdef DECODE_ILLEGAL_TRAP_EN
  typedef enum logic {RUN = 1'b0, TRAP = 1'b1} state_t;
  state_t state;
`endif

  logic [5:0]           op;
  logic [5:0]           fn;
  logic [4:0]           dec_funct;
  logic                 dec_alu_src;
  logic [IMM_WIDTH-1:0] dec_imm;
  logic [4:0]           dec_rs;
  logic [4:0]           dec_rt;
  logic [4:0]           dec_rd;
  logic                 dec_we;
  logic                 dec_mem_rd;
  logic                 dec_mem_wr;
  logic                 dec_branch;
  logic                 dec_illegal;
  logic                 accept;
  logic                 drain;

  assign op = d_i_instr[31:26];
  assign fn = d_i_instr[5:0];

  always_comb begin
    dec_funct   = FN_NONE;
    dec_alu_src = 1'b0;
    dec_imm     = IMM_WIDTH'(d_i_instr[15:0]);
    dec_rs      = d_i_instr[25:21];
    dec_rt      = d_i_instr[20:16];
    dec_rd      = 5'd0;
    dec_we      = 1'b0;
    dec_mem_rd  = 1'b0;
    dec_mem_wr  = 1'b0;
    dec_branch  = 1'b0;
    dec_illegal = 1'b0;
    if (d_i_instr != 32'd0) begin
      unique case (op)
        6'h00: begin
          dec_we = 1'b1;
          dec_rd = d_i_instr[15:11];
          unique case (fn)
            6'h20: dec_funct = FN_ADD;
            6'h21: dec_funct = FN_ADDU;
            6'h22, 6'h23: dec_funct = FN_SUB;
            6'h24: dec_funct = FN_AND;
            6'h25: dec_funct = FN_OR;
            6'h26: dec_funct = FN_XOR;
            6'h2A: dec_funct = FN_SLT;
            6'h2B: dec_funct = FN_SLTU;
            // The ALU shifts operand A, so the shifted register (rt) is routed to rs.
            6'h00, 6'h02, 6'h03: begin
              dec_rs      = d_i_instr[20:16];
              dec_imm     = IMM_WIDTH'(d_i_instr[10:6]);
              dec_alu_src = 1'b1;
              dec_funct   = (fn == 6'h00) ? FN_SLL : ((fn == 6'h02) ? FN_SRL : FN_SRA);
            end
            default: begin
              dec_we      = 1'b0;
              dec_rd      = 5'd0;
              dec_illegal = 1'b1;
            end
          endcase
        end
        6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E: begin
          dec_alu_src = 1'b1;
          dec_rd      = d_i_instr[20:16];
          dec_we      = 1'b1;
          unique case (op)
            6'h08:   dec_funct = FN_ADD;
            6'h09:   dec_funct = FN_ADDU;
            6'h0A:   dec_funct = FN_SLT;
            6'h0B:   dec_funct = FN_SLTU;
            6'h0C:   dec_funct = FN_AND;
            6'h0D:   dec_funct = FN_OR;
            default: dec_funct = FN_XOR;
          endcase
        end
        6'h23: begin
          dec_funct   = FN_ADD;
          dec_alu_src = 1'b1;
          dec_mem_rd  = 1'b1;
          dec_we      = 1'b1;
          dec_rd      = d_i_instr[20:16];
        end
        6'h2B: begin
          dec_funct   = FN_ADD;
          dec_alu_src = 1'b1;
          dec_mem_wr  = 1'b1;
        end
        6'h04, 6'h05: begin
          dec_funct  = (op == 6'h04) ? FN_BEQ : FN_BNE;
          dec_branch = 1'b1;
        end
        default: dec_illegal = 1'b1;
      endcase
    end
  end

`ifdef DECODE_ILLEGAL_TRAP_EN
  assign d_o_ready = (!d_o_valid || d_i_ready) && (state == RUN);
`else
  assign d_o_ready = !d_o_valid || d_i_ready;
`endif

  assign accept = d_i_valid && d_o_ready;
  assign drain  = d_o_valid && d_i_ready;

  always_ff @(posedge d_clk or posedge d_rst) begin
    if (d_rst) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
      state       <= RUN;
`endif
      d_o_valid   <= 1'b0;
      d_o_funct   <= 5'd0;
      d_o_alu_src <= 1'b0;
      d_o_imm     <= '0;
      d_o_pc      <= '0;
      d_o_rs_addr <= 5'd0;
      d_o_rt_addr <= 5'd0;
      d_o_rd_addr <= 5'd0;
      d_o_reg_we  <= 1'b0;
      d_o_mem_rd  <= 1'b0;
      d_o_mem_wr  <= 1'b0;
      d_o_branch  <= 1'b0;
      d_o_illegal <= 1'b0;
    end else if (d_i_flush) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
      state     <= RUN;
`endif
      d_o_valid <= 1'b0;
    end else if (accept) begin
`ifdef DECODE_ILLEGAL_TRAP_EN
      if (dec_illegal) state <= TRAP;
`endif
      d_o_valid   <= 1'b1;
      d_o_funct   <= dec_funct;
      d_o_alu_src <= dec_alu_src;
      d_o_imm     <= dec_imm;
      d_o_pc      <= d_i_pc;
      d_o_rs_addr <= dec_rs;
      d_o_rt_addr <= dec_rt;
      d_o_rd_addr <= dec_rd;
      d_o_reg_we  <= dec_we;
      d_o_mem_rd  <= dec_mem_rd;
      d_o_mem_wr  <= dec_mem_wr;
      d_o_branch  <= dec_branch;
      d_o_illegal <= dec_illegal;
    end else if (drain) begin
      d_o_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_decode_stage.sv
// Directed-vector bench for alu_decode_stage; expected values are hand-decoded from the MIPS encodings.
module tb_alu_decode_stage;

  logic        d_clk = 1'b0;
  logic        d_rst;
  logic [31:0] d_i_instr;
  logic [31:0] d_i_pc;
  logic        d_i_valid;
  logic        d_o_ready;
  logic        d_i_ready;
  logic        d_i_flush;
  logic        d_o_valid;
  logic [4:0]  d_o_funct;
  logic        d_o_alu_src;
  logic [15:0] d_o_imm;
  logic [31:0] d_o_pc;
  logic [4:0]  d_o_rs_addr;
  logic [4:0]  d_o_rt_addr;
  logic [4:0]  d_o_rd_addr;
  logic        d_o_reg_we;
  logic        d_o_mem_rd;
  logic        d_o_mem_wr;
  logic        d_o_branch;
  logic        d_o_illegal;

  int tests_run    = 0;
  int tests_failed = 0;

  alu_decode_stage #(.DWIDTH(32), .PC_WIDTH(32), .IMM_WIDTH(16)) dut (
    .d_clk(d_clk), .d_rst(d_rst), .d_i_instr(d_i_instr), .d_i_pc(d_i_pc),
    .d_i_valid(d_i_valid), .d_o_ready(d_o_ready), .d_i_ready(d_i_ready),
    .d_i_flush(d_i_flush), .d_o_valid(d_o_valid), .d_o_funct(d_o_funct),
    .d_o_alu_src(d_o_alu_src), .d_o_imm(d_o_imm), .d_o_pc(d_o_pc),
    .d_o_rs_addr(d_o_rs_addr), .d_o_rt_addr(d_o_rt_addr), .d_o_rd_addr(d_o_rd_addr),
    .d_o_reg_we(d_o_reg_we), .d_o_mem_rd(d_o_mem_rd), .d_o_mem_wr(d_o_mem_wr),
    .d_o_branch(d_o_branch), .d_o_illegal(d_o_illegal)
  );

  always #5 d_clk = ~d_clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Advance one edge; inputs are then changed 1ns after it, away from the edge.
  task automatic tick();
    @(posedge d_clk);
    #1;
  endtask

  // funct, alu_src, imm, rd, we, mem_rd, mem_wr, branch, illegal of the held entry
  task automatic chk_out(input string tag, input logic [4:0] funct, input logic alu_src,
                         input logic [15:0] imm, input logic [4:0] rd, input logic we,
                         input logic mrd, input logic mwr, input logic br, input logic ill);
    chk({tag, ".valid"},   32'(d_o_valid), 32'd1);
    chk({tag, ".funct"},   32'(d_o_funct), 32'(funct));
    chk({tag, ".alu_src"}, 32'(d_o_alu_src), 32'(alu_src));
    chk({tag, ".imm"},     32'(d_o_imm), 32'(imm));
    chk({tag, ".rd"},      32'(d_o_rd_addr), 32'(rd));
    chk({tag, ".we"},      32'(d_o_reg_we), 32'(we));
    chk({tag, ".mem_rd"},  32'(d_o_mem_rd), 32'(mrd));
    chk({tag, ".mem_wr"},  32'(d_o_mem_wr), 32'(mwr));
    chk({tag, ".branch"},  32'(d_o_branch), 32'(br));
    chk({tag, ".illegal"}, 32'(d_o_illegal), 32'(ill));
  endtask

  task automatic chk_reset_outs(input string tag);
    chk({tag, ".valid"}, 32'(d_o_valid), 32'd0);
    chk({tag, ".funct"}, 32'(d_o_funct), 32'd0);
    chk({tag, ".imm"},   32'(d_o_imm), 32'd0);
    chk({tag, ".pc"},    d_o_pc, 32'd0);
    chk({tag, ".rs"},    32'(d_o_rs_addr), 32'd0);
    chk({tag, ".rd"},    32'(d_o_rd_addr), 32'd0);
    chk({tag, ".flags"}, 32'({d_o_alu_src, d_o_reg_we, d_o_mem_rd, d_o_mem_wr, d_o_branch, d_o_illegal}), 32'd0);
  endtask

  initial begin
    d_rst = 1'b1; d_i_instr = 32'd0; d_i_pc = 32'd0;
    d_i_valid = 1'b0; d_i_ready = 1'b1; d_i_flush = 1'b0;
    tick(); tick();
    chk_reset_outs("rst_init");
    d_rst = 1'b0;
    #1 chk("rst_init.ready", 32'(d_o_ready), 32'd1);

    // add $3,$1,$2 held for three cycles by downstream stall
    tick();
    d_i_instr = 32'h0022_1820; d_i_pc = 32'h100; d_i_valid = 1'b1; d_i_ready = 1'b0;
    tick();
    d_i_valid = 1'b0;
    chk_out("add", 5'd0, 1'b0, 16'h1820, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("add.rs", 32'(d_o_rs_addr), 32'd1);
    chk("add.rt", 32'(d_o_rt_addr), 32'd2);
    chk("add.pc", d_o_pc, 32'h100);
    for (int i = 0; i < 3; i++) begin
      chk("add.hold_ready", 32'(d_o_ready), 32'd0);
      chk("add.hold_valid", 32'(d_o_valid), 32'd1);
      chk("add.hold_funct_rd", 32'({d_o_funct, d_o_rd_addr}), 32'({5'd0, 5'd3}));
      tick();
    end
    d_i_ready = 1'b1;
    #1 chk("add.drain_ready", 32'(d_o_ready), 32'd1);
    tick();
    chk("add.drained", 32'(d_o_valid), 32'd0);

    // sll $4,$5,3 : rt routed to rs, shamt in imm
    d_i_instr = 32'h0005_20C0; d_i_valid = 1'b1;
    tick();
    d_i_valid = 1'b0;
    chk_out("sll", 5'd7, 1'b1, 16'h0003, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    chk("sll.rs", 32'(d_o_rs_addr), 32'd5);
    tick();

    // addi then beq on consecutive cycles
    d_i_instr = 32'h2002_FFFF; d_i_valid = 1'b1;
    tick();
    d_i_instr = 32'h1022_0004;
    chk_out("addi", 5'd0, 1'b1, 16'hFFFF, 5'd2, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    #1 chk("addi.ready", 32'(d_o_ready), 32'd1);
    tick();
    d_i_valid = 1'b0;
    chk_out("beq", 5'd15, 1'b0, 16'h0004, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    chk("beq.rs_rt", 32'({d_o_rs_addr, d_o_rt_addr}), 32'({5'd1, 5'd2}));
    tick();
    chk("beq.drained", 32'(d_o_valid), 32'd0);

    // lw $3,8($2), sw $3,8($2), or $5,$6,$7, bne, xori, NOP
    d_i_valid = 1'b1; d_i_instr = 32'h8C43_0008;
    tick();
    d_i_instr = 32'hAC43_0008;
    chk_out("lw", 5'd0, 1'b1, 16'h0008, 5'd3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick();
    d_i_instr = 32'h00C7_2825;
    chk_out("sw", 5'd0, 1'b1, 16'h0008, 5'd0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0);
    tick();
    d_i_instr = 32'h1485_FFFE;
    chk_out("or", 5'd3, 1'b0, 16'h2825, 5'd5, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    d_i_instr = 32'h38A4_00F0;
    chk_out("bne", 5'd16, 1'b0, 16'hFFFE, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
    tick();
    d_i_instr = 32'h0000_0000;
    chk_out("xori", 5'd4, 1'b1, 16'h00F0, 5'd4, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
    tick();
    d_i_instr = 32'hFC00_0000; d_i_pc = 32'h200;
    chk_out("nop", 5'd31, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0);

    // illegal opcode 0x3F
    tick();
    d_i_instr = 32'h2003_0005;
    chk_out("ill", 5'd31, 1'b0, 16'h0000, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("ill.pc", d_o_pc, 32'h200);
`ifdef DECODE_ILLEGAL_TRAP_EN
    #1 chk("trap.ready0", 32'(d_o_ready), 32'd0);
    tick();
    chk("trap.drained", 32'(d_o_valid), 32'd0);
    chk("trap.ready_held", 32'(d_o_ready), 32'd0);
    d_i_flush = 1'b1;
    tick();
    d_i_flush = 1'b0; d_i_valid = 1'b0;
    chk("trap.flush_valid", 32'(d_o_valid), 32'd0);
    #1 chk("trap.flush_ready", 32'(d_o_ready), 32'd1);
`else
    #1 chk("ill.ready", 32'(d_o_ready), 32'd1);
    tick();
    d_i_valid = 1'b0;
    chk_out("ill.next", 5'd0, 1'b1, 16'h0005, 5'd3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0);
`endif
    tick();

    // flush with a held entry and a valid incoming lw
    d_i_ready = 1'b0; d_i_valid = 1'b1; d_i_instr = 32'h2002_0007;
    tick();
    chk("flush.held", 32'(d_o_valid), 32'd1);
    d_i_instr = 32'h8C43_0008; d_i_flush = 1'b1;
    tick();
    chk("flush.valid", 32'(d_o_valid), 32'd0);
    d_i_flush = 1'b0; d_i_valid = 1'b0; d_i_ready = 1'b1;
    tick();
    chk("flush.lw_dropped", 32'(d_o_valid), 32'd0);
    chk("flush.kept_funct", 32'({d_o_mem_rd, d_o_imm}), 32'h0_0007);

    // reset asserted mid-transfer clears without waiting for an edge
    d_i_ready = 1'b0; d_i_valid = 1'b1; d_i_instr = 32'h2002_FFFF; d_i_pc = 32'h300;
    tick();
    chk("mid.held", 32'(d_o_valid), 32'd1);
    d_rst = 1'b1;
    #1 chk_reset_outs("rst_mid");
    tick();
    d_rst = 1'b0; d_i_valid = 1'b0;
    #1 chk("rst_mid.ready", 32'(d_o_ready), 32'd1);
    chk("rst_mid.valid", 32'(d_o_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/alu_decode_stage.md
# alu_decode_stage

Registered MIPS instruction decode stage that produces the operand-select and function-code stream consumed by the combinational ALU (`funct` 0–16, `alu_src`, 16-bit immediate, PC). It sits between instruction fetch and the execute stage, holds one decoded instruction in an output register, and moves it on with a valid/ready handshake. It supports stall and flush, and can optionally trap on illegal opcodes.

## Interface
Parameters:
- `DWIDTH`, 32: datapath width. Only passed through to keep parameter lists uniform.
- `PC_WIDTH`, 32: PC width.
- `IMM_WIDTH`, 16: immediate width.

Ports:
- `d_clk`  in  1  clock; all state changes on the rising edge.
- `d_rst`  in  1  reset, asynchronous, active-high.
- `d_i_instr`  in  32  instruction word.
- `d_i_pc`  in  PC_WIDTH  PC of `d_i_instr`.
- `d_i_valid`  in  1  upstream holds a valid instruction.
- `d_o_ready`  out  1  stage accepts this cycle.
- `d_i_ready`  in  1  execute stage accepts the output.
- `d_i_flush`  in  1  discard the held and incoming instruction; clears trap.
- `d_o_valid`  out  1  output register holds a decoded instruction.
- `d_o_funct`  out  5  ALU function code; 31 means none.
- `d_o_alu_src`  out  1  1 selects the immediate as operand 2.
- `d_o_imm`  out  IMM_WIDTH  immediate, raw.
- `d_o_pc`  out  PC_WIDTH  registered PC.
- `d_o_rs_addr`, `d_o_rt_addr`, `d_o_rd_addr`  out  5 each  operand A, operand B and write register.
- `d_o_reg_we`, `d_o_mem_rd`, `d_o_mem_wr`, `d_o_branch`  out  1 each  control flags.
- `d_o_illegal`  out  1  held instruction has an unrecognised encoding.

## Operation
- **Handshake.** Accept when `d_i_valid && d_o_ready`. `d_o_ready = (!d_o_valid || d_i_ready) && state==RUN`.
- **R-type (op 0), `rd_addr` = rd, `we` = 1:**
  - `add` 0x20→0, `addu` 0x21→14, `sub` 0x22 and `subu` 0x23→1.
  - `and` 0x24→2, `or` 0x25→3, `xor` 0x26→4, `slt` 0x2A→5, `sltu` 0x2B→6.
- **Shifts (R-type):** `sll` 0x00→7, `srl` 0x02→8, `sra` 0x03→9.
  - The ALU shifts operand A, so set `rs_addr` = instr[20:16] (the rt field).
  - Set `imm` = {11'b0, shamt} and `alu_src` = 1.
- **I-type, `alu_src` = 1, `rd_addr` = rt, `we` = 1:**
  - `addi` 0x08→0, `addiu` 0x09→14, `slti` 0x0A→5, `sltiu` 0x0B→6.
  - `andi` 0x0C→2, `ori` 0x0D→3, `xori` 0x0E→4.
  - Logical immediates are passed raw; the ALU sign-extends them. This is a documented limitation.
- **Loads and stores:**
  - `lw` 0x23 → funct 0, `alu_src` 1, `mem_rd` 1, `we` 1.
  - `sw` 0x2B → funct 0, `alu_src` 1, `mem_wr` 1, `we` 0.
- **Branches:** `beq` 0x04→15, `bne` 0x05→16, with `branch` 1, `alu_src` 0, `we` 0, `imm` = offset.
- **All-zero word:** treated as NOP: funct 31, all flags 0, legal.
- **Anything else:** illegal. funct 31, all flags 0, `d_o_illegal` 1.
- **State machine:**
  - RUN → TRAP when an illegal instruction is accepted (with `DECODE_ILLEGAL_TRAP_EN` only).
  - TRAP → RUN on `d_i_flush`.

## Timing
- Latency: 1 cycle from accept to `d_o_valid`.
- Throughput: one instruction per cycle while `d_i_ready` is high.
- **Hold:** while `d_o_valid && !d_i_ready`, every output stays stable and `d_o_ready` = 0.
- **Simultaneous accept and drain:** the register reloads in the same edge, with no bubble.
- **Flush priority:** `d_i_flush` beats every other input. Next cycle `d_o_valid` = 0 and state = RUN; the incoming instruction is dropped.
- **Reset values:** state RUN, every output register 0 (including `d_o_valid`, funct, flags and addresses). Asserting reset mid-transfer clears immediately; no handshake completes.
- **Idle:** without an accept or drain the register keeps its value. `d_o_valid` falls after a drain with no new accept.

## Configuration
- `DECODE_ILLEGAL_TRAP_EN` defined: after an illegal instruction is accepted the stage enters TRAP.
  - The illegal entry is still presented and drained.
  - `d_o_ready` stays 0 until `d_i_flush`.
- `DECODE_ILLEGAL_TRAP_EN` not defined: there is no TRAP state. Illegal instructions flow through as NOP with `d_o_illegal` = 1, and the stream continues.

## Test plan
- **Reset:** raise `d_rst` mid-stream → all outputs 0 and `d_o_ready` = 1 immediately after reset is released.
- **R-type with stall:** `add $3,$1,$2` (0x00221820) with `d_i_ready` = 0 for 3 cycles.
  - Expect funct 0, rs 1, rt 2, rd 3, `we` 1, held stable for 3 cycles, `d_o_ready` 0.
  - Expect one transfer when `d_i_ready` rises.
- **Shift remap:** `sll $4,$5,3` (0x000520C0) → funct 7, rs 5, `imm` 0x0003, `alu_src` 1, rd 4.
- **Back-to-back stream:** `addi $2,$0,-1` (0x2002FFFF) then `beq $1,$2,4` (0x10220004).
  - First result: funct 0, `imm` 0xFFFF, rd 2.
  - Second result: funct 15, `branch` 1, `we` 0.
  - Both appear on consecutive cycles.
- **Illegal opcode 0x3F with trap enabled:** `d_o_illegal` 1, then `d_o_ready` held 0. Flush → `d_o_valid` 0 and `d_o_ready` 1.
  - Without the macro: the next instruction is accepted the following cycle.
- **Flush with both sides active:** `d_i_flush` with `d_i_valid` and a held entry → `d_o_valid` 0 next cycle; the incoming `lw` is never output.
